// File: rtl/alu_request_sequencer.sv
// Initiator front end for the ALU top level: buffers tagged requests in a FIFO,
// drives one ALU operation at a time, and returns the fixed-latency result.
module alu_request_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [4:0]  req_number1,
  input  logic [4:0]  req_number2,
  input  logic [5:0]  req_operator,
  input  logic [3:0]  req_tag,
  output logic        alu_mode,
  output logic [4:0]  alu_number1,
  output logic [4:0]  alu_number2,
  output logic [5:0]  alu_operator_mode,
  input  logic [31:0] alu_output_num,
  input  logic        alu_balance,
  input  logic        alu_equality,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_balance,
  output logic        rsp_equality,
  output logic [3:0]  rsp_tag,
  output logic        busy,
  output logic [15:0] rsp_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int EW = 21;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    tag_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign req_ready = !fifo_full && !reset;
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {req_mode, req_number1, req_number2, req_operator, req_tag};
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      state             <= S_IDLE;
      cnt               <= '0;
      tag_q             <= '0;
      alu_mode          <= 1'b0;
      alu_number1       <= '0;
      alu_number2       <= '0;
      alu_operator_mode <= '0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_balance       <= 1'b0;
      rsp_equality      <= 1'b0;
      rsp_tag           <= '0;
      rsp_count         <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            rd_ptr            <= rd_ptr + (AW+1)'(1);
            {alu_mode, alu_number1, alu_number2, alu_operator_mode, tag_q} <= head;
            cnt               <= CW'(LATENCY);
            state             <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Result is sampled one edge after it has settled at the ALU outputs.
          if (cnt == '0) begin
            rsp_data     <= alu_output_num;
            rsp_balance  <= alu_balance;
            rsp_equality <= alu_equality;
            rsp_tag      <= tag_q;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_count <= rsp_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_request_sequencer.sv
// Bench for alu_request_sequencer: behavioural ALU stub, in-order scoreboard,
// directed timing/corner scenarios and a randomized traffic phase.
module tb_alu_request_sequencer;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        Clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_mode;
  logic [4:0]  req_number1, req_number2;
  logic [5:0]  req_operator;
  logic [3:0]  req_tag;
  logic        alu_mode;
  logic [4:0]  alu_number1, alu_number2;
  logic [5:0]  alu_operator_mode;
  logic [31:0] alu_output_num;
  logic        alu_balance, alu_equality;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_balance, rsp_equality;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [15:0] rsp_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp    = 0;
  bit chk_en   = 1'b0;

  always #5 Clk = ~Clk;

  alu_request_sequencer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clk(Clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_number1(req_number1), .req_number2(req_number2),
    .req_operator(req_operator), .req_tag(req_tag),
    .alu_mode(alu_mode), .alu_number1(alu_number1), .alu_number2(alu_number2),
    .alu_operator_mode(alu_operator_mode),
    .alu_output_num(alu_output_num), .alu_balance(alu_balance), .alu_equality(alu_equality),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_balance(rsp_balance), .rsp_equality(rsp_equality), .rsp_tag(rsp_tag),
    .busy(busy), .rsp_count(rsp_count)
  );

  function automatic logic [31:0] alu_num(input logic m, input logic [4:0] a, input logic [4:0] b,
                                          input logic [5:0] op);
    return ({15'd0, m, op, a, b} + 32'd1) * 32'h9E37_79B1;
  endfunction

  // ALU stub: result of the current alu_* inputs appears LATENCY edges later.
  logic [31:0] pipe_num [LATENCY];
  logic        pipe_bal [LATENCY];
  logic        pipe_eq  [LATENCY];
  logic [31:0] noise = '0;

  always @(posedge Clk) begin
    pipe_num[0] <= alu_num(alu_mode, alu_number1, alu_number2, alu_operator_mode);
    pipe_bal[0] <= alu_number1 > alu_number2;
    pipe_eq[0]  <= alu_number1 == alu_number2;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_num[i] <= pipe_num[i-1];
      pipe_bal[i] <= pipe_bal[i-1];
      pipe_eq[i]  <= pipe_eq[i-1];
    end
  end

  assign alu_output_num = pipe_num[LATENCY-1] ^ noise;
  assign alu_balance    = pipe_bal[LATENCY-1];
  assign alu_equality   = pipe_eq[LATENCY-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: every accepted request owes exactly one response, in order.
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        bal;
    logic        eq;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] exp_count = '0;

  always @(posedge Clk) begin
    if (reset) begin
      exp_q.delete();
      exp_count = '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_balance", 32'(rsp_balance), 32'(e.bal));
          check_eq("rsp_equality", 32'(rsp_equality), 32'(e.eq));
        end
        exp_count = exp_count + 16'd1;
        n_rsp++;
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.tag  = req_tag;
        e.data = alu_num(req_mode, req_number1, req_number2, req_operator);
        e.bal  = req_number1 > req_number2;
        e.eq   = req_number1 == req_number2;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en && !reset) begin
      check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
      check_eq("rsp_count", 32'(rsp_count), 32'(exp_count));
    end
  end

  task automatic push_req(input logic m, input logic [4:0] a, input logic [4:0] b,
                          input logic [5:0] op, input logic [3:0] t);
    req_valid = 1'b1; req_mode = m; req_number1 = a; req_number2 = b;
    req_operator = op; req_tag = t;
    @(negedge Clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check_eq(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || rsp_valid) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_data"}, rsp_data, 32'd0);
    check_eq({tag, "_rsp_flags"}, 32'({rsp_balance, rsp_equality}), 32'd0);
    check_eq({tag, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    check_eq({tag, "_alu"}, 32'({alu_mode, alu_number1, alu_number2, alu_operator_mode}), 32'd0);
    check_eq({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] cap_data;
    logic [16:0] cap_alu;
    int accepts, k, n_before;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_mode = 1'b0; req_number1 = '0; req_number2 = '0; req_operator = '0; req_tag = '0;
    repeat (3) @(negedge Clk);
    check_reset_values("por");
    reset = 1'b0;
    #1 check_eq("ready_after_reset", 32'(req_ready), 32'd1);
    chk_en = 1'b1;

    // Single operation with exact latency.
    push_req(1'b0, 5'd5, 5'd3, 6'h01, 4'hA);
    check_eq("alu_before_pop", 32'({alu_mode, alu_number1, alu_number2, alu_operator_mode}), 32'd0);
    for (int c = 1; c <= LATENCY + 2; c++) begin
      @(negedge Clk);
      if (c == 1)
        check_eq("alu_after_pop", 32'({alu_mode, alu_number1, alu_number2, alu_operator_mode}),
                 32'({1'b0, 5'd5, 5'd3, 6'h01}));
      check_eq("rsp_valid_timing", 32'(rsp_valid), 32'(c == LATENCY + 2));
    end
    check_eq("single_data", rsp_data, alu_num(1'b0, 5'd5, 5'd3, 6'h01));
    check_eq("single_flags", 32'({rsp_balance, rsp_equality}), 32'b10);
    check_eq("single_tag", 32'(rsp_tag), 32'hA);
    rsp_ready = 1'b1;
    @(negedge Clk);
    check_eq("single_rsp_cleared", 32'(rsp_valid), 32'd0);
    check_eq("single_count", 32'(rsp_count), 32'd1);

    // Full FIFO: 4 queued + 1 in flight while responses are stalled.
    rsp_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_mode = 1'($urandom); req_number1 = 5'($urandom);
      req_number2 = 5'($urandom); req_operator = 6'($urandom); req_tag = 4'(accepts);
      #1 if (req_ready) accepts++;
      @(negedge Clk);
    end
    req_valid = 1'b0;
    check_eq("full_accepts", 32'(accepts), 32'(DEPTH + 1));
    check_eq("full_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    k = 0;
    for (int n = 0; n < 80 && k < DEPTH + 1; n++) begin
      if (rsp_valid) begin
        check_eq("full_order_tag", 32'(rsp_tag), 32'(k));
        k++;
      end
      @(negedge Clk);
    end
    check_eq("full_rsp_total", 32'(k), 32'(DEPTH + 1));
    wait_idle("full_drain", 40);

    // Back-pressure in RESP with a changing ALU result and a queued request.
    rsp_ready = 1'b0;
    op = 6'($urandom);
    push_req(1'b0, 5'd9, 5'd4, op, 4'd3);
    push_req(1'b1, 5'd2, 5'd2, 6'($urandom), 4'd4);
    wait_rsp("bp_wait", 20);
    cap_data = rsp_data;
    cap_alu  = {alu_mode, alu_number1, alu_number2, alu_operator_mode};
    check_eq("bp_captured", cap_data, alu_num(1'b0, 5'd9, 5'd4, op));
    for (int i = 0; i < 10; i++) begin
      noise = $urandom | 32'd1;
      @(negedge Clk);
      check_eq("bp_rsp_data_hold", rsp_data, cap_data);
      check_eq("bp_alu_hold", 32'({alu_mode, alu_number1, alu_number2, alu_operator_mode}), 32'(cap_alu));
      check_eq("bp_valid_hold", 32'(rsp_valid), 32'd1);
    end
    noise = '0;
    rsp_ready = 1'b1;
    wait_idle("bp_drain", 40);

    // Reset while an op is in WAIT with two entries queued.
    push_req(1'b0, 5'd1, 5'd2, 6'h02, 4'd7);
    push_req(1'b0, 5'd3, 5'd4, 6'h03, 4'd8);
    push_req(1'b0, 5'd5, 5'd6, 6'h04, 4'd9);
    check_eq("midwait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge Clk);
    check_reset_values("midwait");
    reset = 1'b0;
    #1 check_eq("midwait_ready_back", 32'(req_ready), 32'd1);
    n_before = n_rsp;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      check_eq("midwait_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check_eq("midwait_no_handshake", 32'(n_rsp), 32'(n_before));

    // Mode B operation.
    op = 6'($urandom);
    push_req(1'b1, 5'd3, 5'd8, op, 4'd5);
    @(negedge Clk);
    check_eq("modeb_alu", 32'({alu_mode, alu_number1, alu_number2}), 32'({1'b1, 5'd3, 5'd8}));
    wait_rsp("modeb_wait", 20);
    check_eq("modeb_data", rsp_data, alu_num(1'b1, 5'd3, 5'd8, op));
    check_eq("modeb_tag", 32'(rsp_tag), 32'd5);
    @(negedge Clk);

    // Response counter wrap.
    wait_idle("wrap_idle", 20);
    force dut.rsp_count = 16'hFFFF;
    exp_count = 16'hFFFF;
    #1 release dut.rsp_count;
    check_eq("wrap_preload", 32'(rsp_count), 32'hFFFF);
    push_req(1'b0, 5'd7, 5'd7, 6'h05, 4'd1);
    wait_rsp("wrap_wait", 20);
    @(negedge Clk);
    check_eq("wrap_count", 32'(rsp_count), 32'd0);

    // Randomized traffic with random response back-pressure.
    n_before = n_rsp;
    for (int i = 0; i < 500; i++) begin
      req_valid = 1'($urandom_range(0, 1)); req_mode = 1'($urandom);
      req_number1 = 5'($urandom); req_number2 = 5'($urandom);
      req_operator = 6'($urandom); req_tag = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge Clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand_drain", 100);
    check_eq("rand_progress", 32'(n_rsp - n_before > 20), 32'd1);
    check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
